// File: rtl/exec_stage_mc.sv
// exec_stage_mc: parametrised execute stage with registered {P,V,Z,C} flags,
// a multi-cycle shift-add multiplier and a restoring unsigned divider, and a
// valid/ready/stall handshake towards decode and memory.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepts ops; single-cycle ops complete here
// MUL   | shift-add multiply, one product bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
module exec_stage_mc #(
  parameter int DATA_W = 8,
  parameter int REG_W  = 5,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op_dec,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] data_in,
  input  logic [REG_W-1:0]  RW_dec,
  input  logic              mem_en_dec,
  input  logic              mem_rw_dec,
  input  logic              mem_mux_sel_dec,
  input  logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] ans_ex,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] B_Bypass,
  output logic [REG_W-1:0]  RW_ex,
  output logic              mem_en_ex,
  output logic              mem_rw_ex,
  output logic              mem_mux_sel_ex,
  output logic [3:0]        flag_ex,
  output logic              busy
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   acc_hi_q, acc_lo_q, opnd_q;
  logic [DATA_W-1:0]   pend_b_q;
  logic [REG_W-1:0]    pend_rw_q;
  logic                pend_men_q, pend_mrw_q, pend_mux_q;

  logic                accept, finish;
  logic                is_mul, is_div;
  logic [DATA_W-1:0]   sc_res;
  logic                sc_c, sc_v, sc_ld_ans, sc_ld_flags, sc_ld_dout;

  logic [DATA_W:0]     add_sum, sub_sum;
  logic [SH_W-1:0]     shamt;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W-1:0]   mul_hi_d, mul_lo_d;
  logic [DATA_W:0]     div_shift;
  logic                div_ge;
  logic [DATA_W-1:0]   div_diff, div_hi_d, div_lo_d;

  logic                produce, use_pend;
  logic [DATA_W-1:0]   res;
  logic                res_c, res_v, ld_ans, ld_flags, ld_dout;

  assign in_ready = !reset && (state_q == IDLE) && !(out_valid && stall);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != IDLE);

  assign add_sum = {1'b0, A} + {1'b0, B};
  assign sub_sum = {1'b0, A} + {1'b0, ~B} + {{DATA_W{1'b0}}, 1'b1};
  assign shamt   = B[SH_W-1:0];

  // One multiply step: conditionally add the multiplicand, then shift right.
  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi_d = mul_sum[DATA_W:1];
  assign mul_lo_d = {mul_sum[0], acc_lo_q[DATA_W-1:1]};

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
  assign div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_diff  = div_shift[DATA_W-1:0] - opnd_q;
  assign div_hi_d  = div_ge ? div_diff : div_shift[DATA_W-1:0];
  assign div_lo_d  = {acc_lo_q[DATA_W-2:0], div_ge};

  // Opcode decode and single-cycle ALU.
  always_comb begin
    sc_res      = ans_ex;
    sc_c        = 1'b0;
    sc_v        = 1'b0;
    sc_ld_ans   = 1'b1;
    sc_ld_flags = 1'b1;
    sc_ld_dout  = 1'b0;
    is_mul      = 1'b0;
    is_div      = 1'b0;
    casez (op_dec)
      5'b0?000: begin
        sc_res = add_sum[DATA_W-1:0];
        sc_c   = add_sum[DATA_W];
        sc_v   = (A[DATA_W-1] == B[DATA_W-1]) && (add_sum[DATA_W-1] != A[DATA_W-1]);
      end
      5'b0?001: begin
        sc_res = sub_sum[DATA_W-1:0];
        sc_c   = sub_sum[DATA_W];
        sc_v   = (A[DATA_W-1] != B[DATA_W-1]) && (sub_sum[DATA_W-1] != A[DATA_W-1]);
      end
      5'b0?010: sc_res = B;
      5'b0?100: sc_res = A & B;
      5'b0?101: sc_res = A | B;
      5'b0?110: sc_res = A ^ B;
      5'b0?111: sc_res = ~B;
      5'b00011: begin
        is_mul      = 1'b1;
        sc_ld_ans   = 1'b0;
        sc_ld_flags = 1'b0;
      end
      5'b01011: begin
        is_div      = 1'b1;
        sc_ld_ans   = 1'b0;
        sc_ld_flags = 1'b0;
      end
      5'b1010?: begin
        sc_res      = A;
        sc_ld_flags = 1'b0;
      end
      5'b10110: sc_res = data_in;
      5'b10111: begin
        sc_ld_ans   = 1'b0;
        sc_ld_flags = 1'b0;
        sc_ld_dout  = 1'b1;
      end
      5'b11001: sc_res = A << shamt;
      5'b11010: sc_res = A >> shamt;
      5'b11011: sc_res = $signed(A) >>> shamt;
      default: begin
        sc_ld_ans   = 1'b0;
        sc_ld_flags = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; finish fires on the last iteration of MUL/DIV.
  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && is_mul)      state_d = MUL;
        else if (accept && is_div) state_d = DIV;
      end
      MUL, DIV: begin
        if (cnt_q == '0) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Iteration counter, operand latch and partial-result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
    end else if (accept && is_mul) begin
      cnt_q    <= CNT_W'(DATA_W - 1);
      acc_hi_q <= '0;
      acc_lo_q <= B;
      opnd_q   <= A;
    end else if (accept && is_div) begin
      cnt_q    <= CNT_W'(DATA_W - 1);
      acc_hi_q <= '0;
      acc_lo_q <= A;
      opnd_q   <= B;
    end else if (state_q == MUL) begin
      cnt_q    <= cnt_q - CNT_W'(1);
      acc_hi_q <= mul_hi_d;
      acc_lo_q <= mul_lo_d;
    end else if (state_q == DIV) begin
      cnt_q    <= cnt_q - CNT_W'(1);
      acc_hi_q <= div_hi_d;
      acc_lo_q <= div_lo_d;
    end
  end

  // Pass-through fields captured at accept, presented when a multi-cycle op ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_b_q   <= '0;
      pend_rw_q  <= '0;
      pend_men_q <= 1'b0;
      pend_mrw_q <= 1'b0;
      pend_mux_q <= 1'b0;
    end else if (accept) begin
      pend_b_q   <= B;
      pend_rw_q  <= RW_dec;
      pend_men_q <= mem_en_dec;
      pend_mrw_q <= mem_rw_dec;
      pend_mux_q <= mem_mux_sel_dec;
    end
  end

  // Select which result (single-cycle or multi-cycle) gets written this cycle.
  always_comb begin
    produce  = 1'b0;
    use_pend = 1'b0;
    res      = sc_res;
    res_c    = sc_c;
    res_v    = sc_v;
    ld_ans   = 1'b0;
    ld_flags = 1'b0;
    ld_dout  = 1'b0;
    if (finish) begin
      produce  = 1'b1;
      use_pend = 1'b1;
      ld_ans   = 1'b1;
      ld_flags = 1'b1;
      res_c    = 1'b0;
      res_v    = 1'b0;
      if (state_q == MUL) begin
        res   = mul_lo_d;
        res_c = |mul_hi_d;
        res_v = |mul_hi_d;
      end else if (opnd_q == '0) begin
        res   = '1;
        res_c = 1'b1;
      end else begin
        res = div_lo_d;
      end
    end else if (accept && !is_mul && !is_div) begin
      produce  = 1'b1;
      ld_ans   = sc_ld_ans;
      ld_flags = sc_ld_flags;
      ld_dout  = sc_ld_dout;
    end
  end

  // Output registers; everything holds while a result waits under stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid      <= 1'b0;
      ans_ex         <= '0;
      data_out       <= '0;
      B_Bypass       <= '0;
      RW_ex          <= '0;
      mem_en_ex      <= 1'b0;
      mem_rw_ex      <= 1'b0;
      mem_mux_sel_ex <= 1'b0;
      flag_ex        <= 4'b0000;
    end else if (produce) begin
      out_valid      <= 1'b1;
      if (ld_ans)   ans_ex   <= res;
      if (ld_flags) flag_ex  <= {^res, res_v, (res == '0), res_c};
      if (ld_dout)  data_out <= A;
      B_Bypass       <= use_pend ? pend_b_q   : B;
      RW_ex          <= use_pend ? pend_rw_q  : RW_dec;
      mem_en_ex      <= use_pend ? pend_men_q : mem_en_dec;
      mem_rw_ex      <= use_pend ? pend_mrw_q : mem_rw_dec;
      mem_mux_sel_ex <= use_pend ? pend_mux_q : mem_mux_sel_dec;
    end else if (!stall) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_stage_mc.sv
// Directed self-checking bench for exec_stage_mc (DATA_W=8).
module tb_exec_stage_mc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] op_dec = '0;
  logic [7:0] A = '0, B = '0, data_in = '0;
  logic [4:0] RW_dec = '0;
  logic       mem_en_dec = 1'b0, mem_rw_dec = 1'b0, mem_mux_sel_dec = 1'b0;
  logic       stall = 1'b0;
  logic       out_valid;
  logic [7:0] ans_ex, data_out, B_Bypass;
  logic [4:0] RW_ex;
  logic       mem_en_ex, mem_rw_ex, mem_mux_sel_ex;
  logic [3:0] flag_ex;
  logic       busy;

  int tests = 0;
  int fails = 0;

  exec_stage_mc #(.DATA_W(8), .REG_W(5), .OP_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_dec(op_dec), .A(A), .B(B), .data_in(data_in), .RW_dec(RW_dec),
    .mem_en_dec(mem_en_dec), .mem_rw_dec(mem_rw_dec), .mem_mux_sel_dec(mem_mux_sel_dec),
    .stall(stall), .out_valid(out_valid), .ans_ex(ans_ex), .data_out(data_out),
    .B_Bypass(B_Bypass), .RW_ex(RW_ex), .mem_en_ex(mem_en_ex), .mem_rw_ex(mem_rw_ex),
    .mem_mux_sel_ex(mem_mux_sel_ex), .flag_ex(flag_ex), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [4:0] rw);
    in_valid = 1'b1;
    op_dec   = op;
    A        = a;
    B        = b;
    RW_dec   = rw;
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst_ans", ans_ex, 0);
    chk("rst_flag", flag_ex, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_dout", data_out, 0);
    reset = 1'b0;
    #1;
    chk("rdy_after_rst", in_ready, 1);

    // ADD 7F+01: signed overflow
    drive(5'b00000, 8'h7F, 8'h01, 5'd3);
    mem_en_dec = 1'b1;
    mem_mux_sel_dec = 1'b1;
    step();
    in_valid = 1'b0;
    mem_en_dec = 1'b0;
    mem_mux_sel_dec = 1'b0;
    chk("add_ans", ans_ex, 8'h80);
    chk("add_flag", flag_ex, 4'b1100);
    chk("add_ov", out_valid, 1);
    chk("add_rw", RW_ex, 3);
    chk("add_byp", B_Bypass, 8'h01);
    chk("add_men", mem_en_ex, 1);
    chk("add_mux", mem_mux_sel_ex, 1);
    chk("add_mrw", mem_rw_ex, 0);
    step();
    chk("add_pulse", out_valid, 0);
    chk("add_hold", ans_ex, 8'h80);

    // SUB 5-5, then PASS A holds flags
    drive(5'b00001, 8'h05, 8'h05, 5'd1);
    step();
    chk("sub_ans", ans_ex, 8'h00);
    chk("sub_flag", flag_ex, 4'b0011);
    drive(5'b10100, 8'h3C, 8'h00, 5'd2);
    step();
    chk("pass_ans", ans_ex, 8'h3C);
    chk("pass_flag", flag_ex, 4'b0011);

    // Shifts (shift amount from B[2:0]), NOP, LOAD
    drive(5'b11001, 8'h81, 8'h09, 5'd1);
    step();
    chk("sll_ans", ans_ex, 8'h02);
    chk("sll_flag", flag_ex, 4'b1000);
    drive(5'b11011, 8'h80, 8'h03, 5'd1);
    step();
    chk("sra_ans", ans_ex, 8'hF0);
    chk("sra_flag", flag_ex, 4'b0000);
    drive(5'b11010, 8'h80, 8'h03, 5'd1);
    step();
    chk("srl_ans", ans_ex, 8'h10);
    chk("srl_flag", flag_ex, 4'b1000);
    drive(5'b10000, 8'h55, 8'h66, 5'd12);
    step();
    chk("nop_ans", ans_ex, 8'h10);
    chk("nop_flag", flag_ex, 4'b1000);
    chk("nop_ov", out_valid, 1);
    chk("nop_rw", RW_ex, 12);
    data_in = 8'h00;
    drive(5'b10110, 8'h55, 8'h66, 5'd1);
    step();
    in_valid = 1'b0;
    chk("load_ans", ans_ex, 8'h00);
    chk("load_flag", flag_ex, 4'b0010);
    step();

    // MUL 10*20, with a second request held off while busy
    drive(5'b00011, 8'h10, 8'h20, 5'd9);
    #1;
    chk("mul_rdy_pre", in_ready, 1);
    step();
    drive(5'b00000, 8'h01, 8'h01, 5'd4);
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy", busy, 1);
      chk("mul_rdy_low", in_ready, 0);
      chk("mul_ov_low", out_valid, 0);
      step();
    end
    chk("mul_ans", ans_ex, 8'h00);
    chk("mul_flag", flag_ex, 4'b0111);
    chk("mul_ov", out_valid, 1);
    chk("mul_busy_end", busy, 0);
    chk("mul_rdy_back", in_ready, 1);
    chk("mul_rw", RW_ex, 9);
    chk("mul_byp", B_Bypass, 8'h20);
    step();
    in_valid = 1'b0;
    chk("add2_ans", ans_ex, 8'h02);
    chk("add2_flag", flag_ex, 4'b1000);
    chk("add2_rw", RW_ex, 4);
    step();

    // DIVU 200/7 and divide by zero
    drive(5'b01011, 8'd200, 8'd7, 5'd5);
    step();
    in_valid = 1'b0;
    repeat (7) begin
      chk("div_ov_low", out_valid, 0);
      step();
    end
    step();
    chk("div_ans", ans_ex, 8'h1C);
    chk("div_flag", flag_ex, 4'b1000);
    chk("div_ov", out_valid, 1);
    step();
    drive(5'b01011, 8'h55, 8'h00, 5'd5);
    step();
    in_valid = 1'b0;
    repeat (8) step();
    chk("div0_ans", ans_ex, 8'hFF);
    chk("div0_flag", flag_ex, 4'b0001);
    chk("div0_ov", out_valid, 1);
    step();
    chk("div0_pulse", out_valid, 0);

    // STORE held by stall for 3 cycles; next op accepted as stall falls
    drive(5'b10111, 8'hA5, 8'h00, 5'd7);
    step();
    chk("st_dout", data_out, 8'hA5);
    chk("st_ans", ans_ex, 8'hFF);
    chk("st_flag", flag_ex, 4'b0001);
    chk("st_ov", out_valid, 1);
    stall = 1'b1;
    drive(5'b00000, 8'h02, 8'h03, 5'd6);
    repeat (3) begin
      #1;
      chk("st_rdy_low", in_ready, 0);
      step();
      chk("st_ov_hold", out_valid, 1);
      chk("st_dout_hold", data_out, 8'hA5);
      chk("st_ans_hold", ans_ex, 8'hFF);
      chk("st_rw_hold", RW_ex, 7);
    end
    stall = 1'b0;
    #1;
    chk("st_rdy_back", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("post_ans", ans_ex, 8'h05);
    chk("post_flag", flag_ex, 4'b0000);
    chk("post_rw", RW_ex, 6);
    chk("post_dout", data_out, 8'hA5);
    step();

    // DIVU aborted by reset 4 cycles in
    drive(5'b01011, 8'd100, 8'd3, 5'd8);
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("abort_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_ans", ans_ex, 0);
    chk("abort_flag", flag_ex, 0);
    chk("abort_dout", data_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ov", out_valid, 0);
    chk("abort_rw", RW_ex, 0);
    chk("abort_rdy", in_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (12) begin
      chk("abort_no_ov", out_valid, 0);
      step();
    end
    drive(5'b00000, 8'h0F, 8'h01, 5'd2);
    #1;
    chk("abort_rdy_back", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("abort_add_ans", ans_ex, 8'h10);
    chk("abort_add_flag", flag_ex, 4'b1000);
    chk("abort_add_ov", out_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exec_stage_mc.md
# exec_stage_mc

Parametrised execute stage for the pipelined MIPS-style core. It replaces the fixed 8-bit execution block with a configurable-width datapath and a registered `{P,V,Z,C}` flag register. It adds a multi-cycle shift-add multiplier and a restoring unsigned divider, and uses a valid/ready/stall handshake so the stage can hold the decode stage while busy and honour back-pressure from the memory stage.

## Interface
Parameters:
- `DATA_W`, 8, datapath width. Power of two, ≥4.
- `REG_W`, 5, destination register address width.
- `OP_W`, 5, opcode width. Only the encodings below are defined.

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- `in_valid`  in  1  decode presents an operation
- `in_ready`  out  1  stage accepts the operation this cycle
- `op_dec`  in  OP_W  opcode
- `A`, `B`, `data_in`  in  DATA_W  operands and load data
- `RW_dec`  in  REG_W  destination register
- `mem_en_dec`, `mem_rw_dec`, `mem_mux_sel_dec`  in  1  memory controls, passed through
- `stall`  in  1  downstream cannot take the result
- `out_valid`  out  1  result registers hold a new result
- `ans_ex`, `data_out`, `B_Bypass`  out  DATA_W  result, store data, B bypass
- `RW_ex`  out  REG_W; `mem_en_ex`, `mem_rw_ex`, `mem_mux_sel_ex`  out  1  registered pass-through
- `flag_ex`  out  4  `{P,V,Z,C}` flag register
- `busy`  out  1  multi-cycle unit active

## Operation
- Accept condition: `in_valid && in_ready`.
- `in_ready = (state==IDLE) && !(out_valid && stall)`.
- States:
  - IDLE: a multi-cycle op moves to MUL or DIV. A single-cycle op stays in IDLE and updates the outputs.
  - MUL, DIV: count DATA_W iterations, then return to IDLE. Operands are latched at accept.
- Single-cycle ops (either encoding):
  - 00000/01000 ADD. C = carry out. V = signed overflow.
  - 00001/01001 SUB, computed as A+~B+1. C = carry out (1 = no borrow). V = signed overflow.
  - 00010/01010 MOVB; 00100/01100 AND; 00101/01101 OR; 00110/01110 XOR; 00111/01111 NOT B.
  - 10100/10101 PASS A. All four flags held.
  - 10110 LOAD: ans = data_in.
  - 10111 STORE: data_out = A; ans and flags held.
  - 11001 SLL, 11010 SRL, 11011 SRA. Shift amount = `B[$clog2(DATA_W)-1:0]`.
- Multi-cycle ops:
  - 00011 MUL: shift-add. ans = low DATA_W bits of the 2·DATA_W product. C = V = (high half ≠ 0).
  - 01011 DIVU: restoring division. ans = quotient, C = 0, V = 0.
  - Divide by zero: ans = all ones, C = 1, V = 0.
- Any other encoding is a NOP: ans_ex and flags held, out_valid still pulses.
- Flag rules:
  - Z = (result == 0). P = XOR of result bits.
  - C and V are 0 for logic, move, shift and LOAD, unless stated above.
  - Flags update only where the op updates ans_ex, except PASS A, which updates ans_ex but holds all flags.
- `data_out` changes only on STORE. Otherwise it holds.
- `B_Bypass`, `RW_ex` and `mem_*_ex` are captured at accept and presented with the result.

## Timing
- Reset value of every output is 0. Exceptions: `in_ready` = 1 after reset is released; state = IDLE.
- Reset asserted mid-MUL/DIV aborts the operation at once. No result is produced.
- Single-cycle op accepted at edge k: outputs and `out_valid=1` registered at edge k.
- Multi-cycle op accepted at edge k:
  - `busy` and `in_ready=0` for edges k+1..k+DATA_W−1.
  - Result and `out_valid=1` at edge k+DATA_W.
  - `in_ready` returns to 1 in the cycle after that edge, if `stall` is low.
- `out_valid` is a one-cycle pulse when `stall` is low. While `out_valid && stall`, all outputs hold and nothing is accepted.
- `stall` arriving while the stage is busy does not pause the computation. It only holds the result once it is produced.

## Test plan
- ADD A=0x7F, B=0x01 → ans_ex=0x80, flag_ex=4'b1100, out_valid one cycle after accept.
- SUB A=0x05, B=0x05 → ans_ex=0x00, flag_ex=4'b0011. Then PASS A=0x3C → ans_ex=0x3C, flag_ex still 4'b0011.
- MUL 0x10×0x20 → ans_ex=0x00, flag_ex=4'b0111 exactly 8 cycles after accept. `in_ready` low in between; a second `in_valid` is ignored until `in_ready` returns to 1.
- DIVU 200/7 → ans_ex=0x1C, C=0. DIVU 0x55/0 → ans_ex=0xFF, C=1.
- STORE A=0xA5 with `stall` high for 3 cycles → data_out=0xA5 and all outputs constant. `in_ready`=0 during the stall; the next op is accepted in the cycle `stall` falls.
- DIVU accepted, `reset` pulsed 4 cycles later → all outputs 0 immediately, `busy`=0, no `out_valid`. A new ADD is accepted after reset release.
